// File: rtl/fc_bias_prep_pkg.sv
// Shared constants and FSM encoding for the FC bias supplier.
// DDR_AXIS_DATA_WIDTH may be overridden by a global define before this file is compiled.
`ifndef DDR_AXIS_DATA_WIDTH
`define DDR_AXIS_DATA_WIDTH 64
`endif

package fc_bias_prep_pkg;

  localparam int DDR_AXIS_DATA_WIDTH = `DDR_AXIS_DATA_WIDTH;
  localparam int BIAS_W              = DDR_AXIS_DATA_WIDTH / 8 * 32;

  typedef enum logic [1:0] {
    FBP_IDLE  = 2'd0,
    FBP_LOAD  = 2'd1,
    FBP_DRAIN = 2'd2
  } fbp_state_e;

  // Width of one assembled bias vector for a given beat width.
  function automatic int bias_vec_w(input int data_w);
    return data_w / 8 * 32;
  endfunction

endpackage

// File: rtl/fc_bias_prep_if.sv
// AXI-Stream bias input bundle: master drives data/valid/last, slave returns ready.

interface fc_bias_prep_if #(
  parameter int DATA_W = 64
) ();

  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/fc_bias_fifo.sv
// Show-ahead register FIFO: dout is always the head entry (zero when empty).
// Simultaneous push and pop on a full FIFO is accepted; flush empties it.

module fc_bias_fifo #(
  parameter int W     = 256,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   push_i,
  input  logic [W-1:0]           din_i,
  input  logic                   pop_i,
  output logic [W-1:0]           dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign count_o = count_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: entries are only visible through the count.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/fc_bias_prep.sv
// Bias supplier: assembles AXIS beats into bias vectors and serves them on read_next_bias.
// Optional protocol checking is built when FC_BIAS_PREP_CHK_EN is defined.

module fc_bias_prep
  import fc_bias_prep_pkg::*;
#(
  parameter int DATA_W     = DDR_AXIS_DATA_WIDTH,
  parameter int BIAS_BEATS = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int NVEC_W     = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [NVEC_W-1:0]      n_vec_i,
  fc_bias_prep_if.slave          s_axis,
  input  logic                   read_next_bias_i,
  output logic [DATA_W/8*32-1:0] bias_o,
  output logic                   bias_vld_o,
  output logic                   busy_o,
  output logic                   err_o
);

  localparam int VEC_W  = bias_vec_w(DATA_W);
  localparam int BEAT_W = (BIAS_BEATS > 1) ? $clog2(BIAS_BEATS) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BIAS_BEATS - 1);

  fbp_state_e        state_q, state_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [NVEC_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [NVEC_W-1:0] n_vec_q, n_vec_d;

  logic [VEC_W-1:0]  push_vec;
  logic [CNT_W-1:0]  fifo_cnt;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic              tready, beat_acc, last_beat, final_vec, final_beat, push;

  always_comb begin
    fifo_pop   = read_next_bias_i && (fifo_cnt >= CNT_W'(2));
    last_beat  = (beat_cnt_q == LAST_BEAT);
    final_vec  = (vec_cnt_q == n_vec_q - 1'b1);
    // Only a beat that would complete a vector with no room is refused.
    tready     = (state_q == FBP_LOAD) && !(fifo_full && last_beat && !fifo_pop);
    beat_acc   = tready && s_axis.tvalid;
    push       = beat_acc && last_beat;
    final_beat = push && final_vec;
  end

  assign s_axis.tready = tready;

  // Earlier beats are staged; the completing beat feeds the FIFO directly.
  for (genvar gi = 0; gi < BIAS_BEATS; gi++) begin : g_lane
    if (gi < BIAS_BEATS - 1) begin : g_stage
      logic [DATA_W-1:0] stage_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_q <= '0;
        else if (beat_acc && beat_cnt_q == BEAT_W'(gi)) stage_q <= s_axis.tdata;
      end
      assign push_vec[gi*DATA_W +: DATA_W] = stage_q;
    end else begin : g_tail
      assign push_vec[gi*DATA_W +: DATA_W] = s_axis.tdata;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    vec_cnt_d  = vec_cnt_q;
    n_vec_d    = n_vec_q;
    case (state_q)
      FBP_LOAD: begin
        if (beat_acc) begin
          beat_cnt_d = last_beat ? '0 : beat_cnt_q + 1'b1;
          if (last_beat) vec_cnt_d = vec_cnt_q + 1'b1;
          if (final_beat) state_d = FBP_DRAIN;
        end
      end
      FBP_DRAIN: if (fifo_cnt <= CNT_W'(1)) state_d = FBP_IDLE;
      default: ;
    endcase
    if (start_i) begin
      state_d    = FBP_LOAD;
      n_vec_d    = (n_vec_i == '0) ? NVEC_W'(1) : n_vec_i;
      beat_cnt_d = '0;
      vec_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FBP_IDLE;
      beat_cnt_q <= '0;
      vec_cnt_q  <= '0;
      n_vec_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      vec_cnt_q  <= vec_cnt_d;
      n_vec_q    <= n_vec_d;
    end
  end

  fc_bias_fifo #(
    .W     (VEC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (start_i),
    .push_i  (push),
    .din_i   (push_vec),
    .pop_i   (fifo_pop),
    .dout_o  (bias_o),
    .count_o (fifo_cnt),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bias_vld_o = !fifo_empty;
  assign busy_o     = (state_q != FBP_IDLE);

`ifdef FC_BIAS_PREP_CHK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (read_next_bias_i && fifo_cnt <= CNT_W'(1) && busy_o) err_d = 1'b1;
    if (beat_acc && s_axis.tlast && !final_beat)              err_d = 1'b1;
    if (final_beat && !s_axis.tlast)                          err_d = 1'b1;
    if (start_i)                                              err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err_o = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis.tlast;
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_fc_bias_prep.sv
// Directed bench for fc_bias_prep with a vector scoreboard fed from accepted beats.
// Expected err values follow FC_BIAS_PREP_CHK_EN.

module tb_fc_bias_prep;

  localparam int DW = 64;
  localparam int BW = DW / 8 * 32;
`ifdef FC_BIAS_PREP_CHK_EN
  localparam logic CHK = 1'b1;
`else
  localparam logic CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [15:0]   n_vec;
  logic          read_next_bias;
  logic [BW-1:0] bias;
  logic          bias_vld, busy, err;

  int checks   = 0;
  int failures = 0;

  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] stage_m;
  int            beat_m;

  fc_bias_prep_if #(.DATA_W(DW)) s_if ();

  fc_bias_prep #(
    .DATA_W(DW), .BIAS_BEATS(4), .FIFO_DEPTH(4), .NVEC_W(16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start_i          (start),
    .n_vec_i          (n_vec),
    .s_axis           (s_if.slave),
    .read_next_bias_i (read_next_bias),
    .bias_o           (bias),
    .bias_vld_o       (bias_vld),
    .busy_o           (busy),
    .err_o            (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [BW-1:0] head_exp();
    return (exp_q.size() > 0) ? exp_q[0] : '0;
  endfunction

  // mode 0: global beat index replicated in every byte; otherwise a unique tagged word.
  function automatic logic [DW-1:0] beat_data(input int mode, input int k);
    logic [7:0] b;
    b = 8'(k);
    if (mode == 0) return {8{b}};
    return {32'(mode) << 24 | 32'h00A50000 | 32'(k), 32'h5E000000 ^ 32'(k * 3)};
  endfunction

  task automatic model_flush();
    exp_q.delete();
    beat_m  = 0;
    stage_m = '0;
  endtask

  task automatic model_beat(input logic [DW-1:0] d);
    stage_m[beat_m*DW +: DW] = d;
    beat_m++;
    if (beat_m == 4) begin
      exp_q.push_back(stage_m);
      beat_m = 0;
    end
  endtask

  // One clock: drive at a negedge, sample before the posedge, advance to the next negedge.
  task automatic cyc(input logic vld, input logic [DW-1:0] d, input logic last,
                     input logic rnb, output logic acc);
    s_if.tvalid    = vld;
    s_if.tdata     = d;
    s_if.tlast     = last;
    read_next_bias = rnb;
    #1;
    acc = vld && s_if.tready;
    if (rnb && exp_q.size() >= 2) chk("pop_head", bias, head_exp());
    @(negedge clk);
    if (rnb && exp_q.size() >= 2) void'(exp_q.pop_front());
    if (acc) model_beat(d);
    s_if.tvalid    = 1'b0;
    s_if.tlast     = 1'b0;
    read_next_bias = 1'b0;
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b0, acc);
  endtask

  task automatic pops(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b1, acc);
  endtask

  task automatic do_start(input int nv);
    start = 1'b1;
    n_vec = 16'(nv);
    @(negedge clk);
    start = 1'b0;
    model_flush();
  endtask

  task automatic send_beats(input int first, input int cnt, input int total,
                            input int bad_last, input int mode);
    logic acc;
    int   tries;
    for (int k = first; k < first + cnt; k++) begin
      tries = 0;
      do begin
        cyc(1'b1, beat_data(mode, k), (k == total - 1) || (k == bad_last), 1'b0, acc);
        tries++;
      end while (!acc && tries < 20);
      if (!acc) chk("beat_timeout", BW'(acc), BW'(1));
    end
  endtask

  initial begin : stim
    logic acc;
    int   k, hold_acc, npop, guard;
    logic [BW-1:0] v7;

    rst_n = 1'b0; start = 1'b0; n_vec = '0; read_next_bias = 1'b0;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0;
    model_flush();
    repeat (2) @(negedge clk);
    chk("rst_tready", BW'(s_if.tready), '0);
    chk("rst_bias", bias, '0);
    chk("rst_vld", BW'(bias_vld), '0);
    chk("rst_busy", BW'(busy), '0);
    chk("rst_err", BW'(err), '0);

    // 1: reset mid-LOAD, then a clean 2-vector layer
    rst_n = 1'b1;
    @(negedge clk);
    do_start(2);
    send_beats(0, 2, 8, -1, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t1_rst_tready", BW'(s_if.tready), '0);
    chk("t1_rst_busy", BW'(busy), '0);
    chk("t1_rst_vld", BW'(bias_vld), '0);
    chk("t1_rst_bias", bias, '0);
    rst_n = 1'b1;
    model_flush();
    @(negedge clk);
    do_start(2);
    send_beats(0, 4, 8, -1, 1);
    chk("t1_vld_latency", BW'(bias_vld), BW'(1));
    chk("t1_vec0", bias, head_exp());
    send_beats(4, 4, 8, -1, 1);
    chk("t1_busy_drain", BW'(busy), BW'(1));
    pops(1);
    idle(2);
    chk("t1_vec1_held", bias, head_exp());
    chk("t1_idle", BW'(busy), '0);

    // 2: replicated-index data, two pops, final vector held
    do_start(3);
    send_beats(0, 4, 12, -1, 0);
    chk("t2_lane0", BW'(bias[31:0]), '0);
    chk("t2_lane2", BW'(bias[95:64]), BW'(32'h01010101));
    send_beats(4, 8, 12, -1, 0);
    pops(2);
    idle(2);
    chk("t2_vec2_held", bias, head_exp());
    chk("t2_vld", BW'(bias_vld), BW'(1));
    chk("t2_busy", BW'(busy), '0);
    chk("t2_err", BW'(err), '0);

    // 3: backpressure with a full FIFO, then drain with a pop every cycle
    do_start(8);
    k = 0;
    guard = 0;
    do begin
      cyc(1'b1, beat_data(2, k), k == 31, 1'b0, acc);
      if (acc) k++;
      guard++;
    end while (acc && guard < 40);
    chk("t3_stall_beat", BW'(k), BW'(19));
    hold_acc = 0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, beat_data(2, k), 1'b0, 1'b0, acc);
      if (acc) hold_acc++;
    end
    chk("t3_stall_hold", BW'(hold_acc), '0);
    npop  = 0;
    guard = 0;
    while ((k < 32 || exp_q.size() > 1) && guard < 200) begin
      if (exp_q.size() >= 2) npop++;
      cyc(k < 32, beat_data(2, k), k == 31, 1'b1, acc);
      if (acc) k++;
      guard++;
    end
    idle(2);
    v7 = {beat_data(2, 31), beat_data(2, 30), beat_data(2, 29), beat_data(2, 28)};
    chk("t3_pop_count", BW'(npop), BW'(7));
    chk("t3_last_vec", bias, v7);
    chk("t3_busy", BW'(busy), '0);

    // 4: pops outrun the stream; head must stop at vector 1
    do_start(3);
    send_beats(0, 8, 12, -1, 1);
    pops(3);
    chk("t4_head_v1", bias, head_exp());
    chk("t4_vld", BW'(bias_vld), BW'(1));
    chk("t4_err", BW'(err), BW'(CHK));
    send_beats(8, 4, 12, -1, 1);
    pops(1);
    idle(2);
    chk("t4_vec2", bias, head_exp());

    // 5: restart mid-layer flushes everything
    do_start(3);
    send_beats(0, 5, 12, -1, 1);
    chk("t5_vld_pre", BW'(bias_vld), BW'(1));
    do_start(1);
    chk("t5_flush_vld", BW'(bias_vld), '0);
    chk("t5_flush_bias", bias, '0);
    send_beats(0, 3, 4, -1, 3);
    chk("t5_partial", BW'(bias_vld), '0);
    send_beats(3, 1, 4, -1, 3);
    chk("t5_new_vld", BW'(bias_vld), BW'(1));
    chk("t5_new_vec", bias, head_exp());
    idle(2);
    chk("t5_busy", BW'(busy), '0);

    // 6: early tlast
    do_start(2);
    send_beats(0, 8, 8, 3, 4);
    chk("t6_err", BW'(err), BW'(CHK));
    chk("t6_vec0", bias, head_exp());
    pops(1);
    idle(2);
    chk("t6_vec1", bias, head_exp());
    chk("t6_busy", BW'(busy), '0);

    // n_vec = 0 behaves as a single vector
    do_start(0);
    send_beats(0, 4, 4, -1, 5);
    idle(2);
    chk("nvec0_vec", bias, head_exp());
    chk("nvec0_busy", BW'(busy), '0);
    chk("nvec0_err", BW'(err), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
